// File: rtl/eaglesong_circulant_sequencer.sv
// Eaglesong circulant-multiplication sequencer: walks the 48-entry coefficient
// table one entry per cycle and folds three rotates into each of the 16 state words.
module eaglesong_circulant_sequencer #(
    parameter int unsigned NUM_WORDS       = 16,
    parameter int unsigned WORD_W          = 32,
    parameter int unsigned COEFFS_PER_WORD = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [NUM_WORDS*WORD_W-1:0]   state_in,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_WORDS*WORD_W-1:0]   state_out,
    output logic [6:0]                    coeff_index,
    input  logic [4:0]                    coeff_value
);

    localparam int unsigned STATE_W    = NUM_WORDS * WORD_W;
    localparam int unsigned WORD_CNT_W = $clog2(NUM_WORDS);
    localparam int unsigned TERM_CNT_W = $clog2(COEFFS_PER_WORD);
    localparam int unsigned IDX_W      = 7;
    localparam int unsigned ROT_W      = 5;
    localparam int unsigned BASE_W     = $clog2(STATE_W);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [STATE_W-1:0]      work_q, work_d;
    logic [WORD_W-1:0]       acc_q, acc_d;
    logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [TERM_CNT_W-1:0]   term_cnt_q, term_cnt_d;
    logic [IDX_W-1:0]        coeff_index_q, coeff_index_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [STATE_W-1:0]      state_out_q, state_out_d;

    // Rotate left; a zero amount leaves the word untouched.
    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x,
                                               input logic [ROT_W-1:0]  amt);
        return (x << amt) | (x >> (WORD_W - 32'(amt)));
    endfunction

    logic [BASE_W-1:0]  word_base_c;
    logic [WORD_W-1:0]  cur_word_c;
    logic [WORD_W-1:0]  term_val_c;
    logic               last_term_c;
    logic               last_word_c;

    // Datapath view of the word currently being processed.
    always_comb begin
        word_base_c = BASE_W'(word_cnt_q) * BASE_W'(WORD_W);
        cur_word_c  = work_q[word_base_c +: WORD_W];
        term_val_c  = ((term_cnt_q == '0) ? cur_word_c : acc_q) ^ rotl(cur_word_c, coeff_value);
        last_term_c = (term_cnt_q == TERM_CNT_W'(COEFFS_PER_WORD - 1));
        last_word_c = (word_cnt_q == WORD_CNT_W'(NUM_WORDS - 1));
    end

    // Next-state and register update logic.
    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        acc_d         = acc_q;
        word_cnt_d    = word_cnt_q;
        term_cnt_d    = term_cnt_q;
        coeff_index_d = coeff_index_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        state_out_d   = state_out_q;

        case (state_q)
            ST_IDLE: begin
                busy_d        = 1'b0;
                coeff_index_d = '0;
                // abort alongside start blocks the request
                if (start && !abort) begin
                    state_d       = ST_RUN;
                    work_d        = state_in;
                    acc_d         = '0;
                    word_cnt_d    = '0;
                    term_cnt_d    = '0;
                    coeff_index_d = '0;
                    busy_d        = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d       = ST_IDLE;
                    busy_d        = 1'b0;
                    word_cnt_d    = '0;
                    term_cnt_d    = '0;
                    coeff_index_d = '0;
                end else if (last_term_c) begin
                    work_d[word_base_c +: WORD_W] = term_val_c;
                    term_cnt_d = '0;
                    if (last_word_c) begin
                        state_d       = ST_IDLE;
                        state_out_d   = work_d;
                        done_d        = 1'b1;
                        busy_d        = 1'b0;
                        word_cnt_d    = '0;
                        coeff_index_d = '0;
                    end else begin
                        word_cnt_d    = word_cnt_q + WORD_CNT_W'(1);
                        coeff_index_d = coeff_index_q + IDX_W'(1);
                    end
                end else begin
                    acc_d         = term_val_c;
                    term_cnt_d    = term_cnt_q + TERM_CNT_W'(1);
                    coeff_index_d = coeff_index_q + IDX_W'(1);
                end
            end
            default: begin
                state_d       = ST_IDLE;
                busy_d        = 1'b0;
                coeff_index_d = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            work_q        <= '0;
            acc_q         <= '0;
            word_cnt_q    <= '0;
            term_cnt_q    <= '0;
            coeff_index_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            state_out_q   <= '0;
        end else begin
            state_q       <= state_d;
            work_q        <= work_d;
            acc_q         <= acc_d;
            word_cnt_q    <= word_cnt_d;
            term_cnt_q    <= term_cnt_d;
            coeff_index_q <= coeff_index_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            state_out_q   <= state_out_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign state_out   = state_out_q;
    assign coeff_index = coeff_index_q;

endmodule

// File: tb/tb_eaglesong_circulant_sequencer.sv
// Directed bench for the circulant sequencer with a behavioural coefficient table.
module tb_eaglesong_circulant_sequencer;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [511:0] state_in;
    logic         busy;
    logic         done;
    logic [511:0] state_out;
    logic [6:0]   coeff_index;
    logic [4:0]   coeff_value;

    int total;
    int bad;
    logic [511:0] last_result;

    localparam logic [4:0] COEFF_TBL [0:47] = '{
        5'd0, 5'd2,  5'd4,   5'd0, 5'd13, 5'd22,  5'd0, 5'd4,  5'd19,  5'd0, 5'd3,  5'd14,
        5'd0, 5'd27, 5'd31,  5'd0, 5'd3,  5'd8,   5'd0, 5'd17, 5'd26,  5'd0, 5'd3,  5'd12,
        5'd0, 5'd18, 5'd22,  5'd0, 5'd12, 5'd18,  5'd0, 5'd4,  5'd7,   5'd0, 5'd4,  5'd31,
        5'd0, 5'd12, 5'd27,  5'd0, 5'd7,  5'd17,  5'd0, 5'd7,  5'd8,   5'd0, 5'd1,  5'd13
    };

    eaglesong_circulant_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .state_in    (state_in),
        .busy        (busy),
        .done        (done),
        .state_out   (state_out),
        .coeff_index (coeff_index),
        .coeff_value (coeff_value)
    );

    // Combinational coefficient table seen by the DUT.
    always_comb begin
        coeff_value = 5'd0;
        if (coeff_index < 7'd48) coeff_value = COEFF_TBL[6'(coeff_index)];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rot32(input logic [31:0] x, input int a);
        if (a == 0) return x;
        return (x << a) | (x >> (32 - a));
    endfunction

    // x ^ rotl(x,c0) ^ rotl(x,c1) ^ rotl(x,c2) per word.
    function automatic logic [511:0] model(input logic [511:0] v);
        logic [511:0] r;
        logic [31:0]  x;
        logic [31:0]  y;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            x = v[32*i +: 32];
            y = x;
            for (int t = 0; t < 3; t++) y = y ^ rot32(x, int'(COEFF_TBL[3*i+t]));
            r[32*i +: 32] = y;
        end
        return r;
    endfunction

    function automatic logic [511:0] rand_state();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start for exactly one accepting edge.
    task automatic start_op(input logic [511:0] v);
        state_in = v;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Count edges until done is seen, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; state_in = '0;
        repeat (2) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (state_out !== 512'd0) begin bad++; $display("FAIL reset_state_out got=%h exp=0", state_out); end
        total++; if (coeff_index !== 7'd0) begin bad++; $display("FAIL reset_coeff_index got=%0d exp=0", coeff_index); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero();
        int cyc;
        start_op('0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy_after_accept got=%b exp=1", busy); end
        wait_done(cyc);
        total++; if (cyc !== 48) begin bad++; $display("FAIL zero_latency got=%0d exp=48", cyc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_at_done got=%b exp=0", busy); end
        total++; if (state_out !== 512'd0) begin bad++; $display("FAIL zero_result got=%h exp=0", state_out); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse_width got=%b exp=0", done); end
        last_result = '0;
    endtask

    // Coefficient 0 on term 0 cancels the word itself, leaving the two real rotates.
    task automatic test_word0();
        int cyc;
        logic [511:0] v;
        logic [511:0] e;
        v = '0; v[31:0] = 32'h0000_0001;
        e = '0; e[31:0] = 32'h0000_0014;
        start_op(v);
        wait_done(cyc);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL word0_done got=%b exp=1", done); end
        total++; if (state_out !== e) begin bad++; $display("FAIL word0_result got=%h exp=%h", state_out, e); end
        last_result = e;
        tick();
    endtask

    task automatic test_wrap();
        int cyc;
        logic [511:0] v;
        v = '0;
        v[63:32]   = 32'h8000_0000;
        v[159:128] = 32'h0000_0001;
        start_op(v);
        wait_done(cyc);
        total++; if (state_out[63:32] !== 32'h0020_1000) begin bad++; $display("FAIL wrap_word1 got=%h exp=00201000", state_out[63:32]); end
        total++; if (state_out[159:128] !== 32'h8800_0000) begin bad++; $display("FAIL wrap_word4 got=%h exp=88000000", state_out[159:128]); end
        total++; if (state_out !== model(v)) begin bad++; $display("FAIL wrap_full got=%h exp=%h", state_out, model(v)); end
        last_result = model(v);
        tick();
    endtask

    task automatic test_index_trace();
        logic [511:0] v;
        int idx_bad;
        v = rand_state();
        idx_bad = 0;
        start_op(v);
        for (int n = 0; n < 48; n++) begin
            total++;
            if (coeff_index !== 7'(n) || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL index_trace n=%0d got idx=%0d busy=%b done=%b exp idx=%0d busy=1 done=0",
                         n, coeff_index, busy, done, n);
            end
            if (n == 10) begin
                state_in = rand_state();
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL trace_done_at_48 got=%b exp=1", done); end
        total++; if (coeff_index !== 7'd0) begin bad++; $display("FAIL trace_idx_at_done got=%0d exp=0", coeff_index); end
        total++; if (state_out !== model(v)) begin bad++; $display("FAIL trace_result got=%h exp=%h", state_out, model(v)); end
        last_result = model(v);
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL trace_idle_after got=%b exp=0", busy); end
    endtask

    task automatic test_abort();
        int saw_done;
        start_op(rand_state());
        repeat (20) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
        total++; if (coeff_index !== 7'd0) begin bad++; $display("FAIL abort_idx got=%0d exp=0", coeff_index); end
        saw_done = 0;
        for (int n = 0; n < 60; n++) begin
            if (done) saw_done++;
            tick();
        end
        total++; if (saw_done !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", saw_done); end
        total++; if (state_out !== last_result) begin bad++; $display("FAIL abort_keeps_result got=%h exp=%h", state_out, last_result); end
        // start together with abort in IDLE is not accepted
        state_in = rand_state();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_abort_idle got=%b exp=0", busy); end
        tick();
    endtask

    task automatic test_reset_mid();
        start_op(rand_state());
        repeat (30) tick();
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b exp=0", done); end
        total++; if (state_out !== 512'd0) begin bad++; $display("FAIL rst_mid_state_out got=%h exp=0", state_out); end
        total++; if (coeff_index !== 7'd0) begin bad++; $display("FAIL rst_mid_idx got=%0d exp=0", coeff_index); end
        tick();
        rst_n = 1'b1;
        last_result = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [511:0] va;
        logic [511:0] vb;
        int cyc1;
        int cyc2;
        va = rand_state();
        vb = rand_state();
        state_in = va;
        start = 1'b1;
        tick();
        state_in = vb;
        wait_done(cyc1);
        total++; if (cyc1 !== 48) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=48", cyc1); end
        total++; if (state_out !== model(va)) begin bad++; $display("FAIL b2b_first_result got=%h exp=%h", state_out, model(va)); end
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got busy=%b done=%b exp busy=1 done=0", busy, done); end
        wait_done(cyc2);
        total++; if (cyc1 + 1 + cyc2 !== 97) begin bad++; $display("FAIL b2b_done_spacing got=%0d exp=49", 1 + cyc2); end
        total++; if (state_out !== model(vb)) begin bad++; $display("FAIL b2b_second_result got=%h exp=%h", state_out, model(vb)); end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        last_result = '0;
        test_reset();
        test_zero();
        test_word0();
        test_wrap();
        test_index_trace();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
